// File: rtl/keypad_msg_buffer_if.sv
// Bundle of keypad, LCD-controller and status signals around the keypad message buffer.
// The buffer itself takes the slave view; whoever drives keys and reads cells takes the master view.
interface keypad_msg_buffer_if;
   logic       key_valid;
   logic [3:0] key_code;
   logic       lcd_ready;
   logic [3:0] rd_addr;
   logic [7:0] char_out;
   logic       message_change;
   logic [4:0] count;
   logic       full;
   logic       overrun;

   modport master (
      output key_valid, key_code, lcd_ready, rd_addr,
      input  char_out, message_change, count, full, overrun
   );

   modport slave (
      input  key_valid, key_code, lcd_ready, rd_addr,
      output char_out, message_change, count, full, overrun
   );
endinterface

// File: rtl/keypad_msg_buffer.sv
// One-line character buffer fed by a keypad: digits append, A clears, B deletes the last character.
// Any change in contents raises a refresh request toward the LCD controller once it is ready.
module keypad_msg_buffer #(
   parameter int          DEPTH = 16,
   parameter logic [7:0]  BLANK = 8'h20
) (
   input logic              clk,
   input logic              reset,
   keypad_msg_buffer_if.slave bus
);

   localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [4:0] DEPTH_C = 5'(DEPTH);
   localparam logic [3:0] KEY_CLR = 4'hA;
   localparam logic [3:0] KEY_BSP = 4'hB;

   typedef enum logic [1:0] {ESPERA, GUARDA, LLENO} state_t;

   state_t      stateQ, stateD;
   logic [3:0]  keyQ, keyD;
   logic [4:0]  countQ, countD;
   logic        pendingQ, pendingD;
   logic        overrunQ, overrunD;
   logic [7:0]  charQ;
   logic [7:0]  cells [DEPTH];
   logic        wrEn;
   logic        commitChanges;
   logic        inDigit;
   logic        inEdit;

   always_comb begin
      inDigit       = (bus.key_code <= 4'd9);
      inEdit        = (bus.key_code == KEY_CLR) || (bus.key_code == KEY_BSP);
      stateD        = stateQ;
      keyD          = keyQ;
      countD        = countQ;
      overrunD      = 1'b0;
      wrEn          = 1'b0;
      commitChanges = 1'b0;

      case (stateQ)
         ESPERA: begin
            if (bus.key_valid && (inDigit || inEdit)) begin
               keyD   = bus.key_code;
               stateD = GUARDA;
            end
         end
         GUARDA: begin
            if (bus.key_valid && (inDigit || inEdit)) begin
               overrunD = 1'b1;
            end
            stateD = ESPERA;
            if (keyQ <= 4'd9) begin
               if (countQ < DEPTH_C) begin
                  wrEn          = 1'b1;
                  countD        = countQ + 5'd1;
                  commitChanges = 1'b1;
                  if (countQ + 5'd1 == DEPTH_C) begin
                     stateD = LLENO;
                  end
               end else begin
                  stateD = LLENO;
               end
            end else if (keyQ == KEY_CLR) begin
               countD        = 5'd0;
               commitChanges = (countQ != 5'd0);
            end else if (keyQ == KEY_BSP) begin
               if (countQ != 5'd0) begin
                  countD        = countQ - 5'd1;
                  commitChanges = 1'b1;
               end
            end
         end
         LLENO: begin
            // Only edit keys can leave the full state; further digits are dropped.
            if (bus.key_valid) begin
               if (inDigit) begin
                  overrunD = 1'b1;
               end else if (inEdit) begin
                  keyD   = bus.key_code;
                  stateD = GUARDA;
               end
            end
         end
         default: stateD = ESPERA;
      endcase

      // A commit on the same edge the request is served keeps the flag set for a second refresh.
      pendingD = commitChanges | (pendingQ & ~bus.lcd_ready);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateQ   <= ESPERA;
         keyQ     <= 4'd0;
         countQ   <= 5'd0;
         pendingQ <= 1'b0;
         overrunQ <= 1'b0;
      end else begin
         stateQ   <= stateD;
         keyQ     <= keyD;
         countQ   <= countD;
         pendingQ <= pendingD;
         overrunQ <= overrunD;
      end
   end

   always_ff @(posedge clk) begin
      if (wrEn) begin
         cells[countQ[AW-1:0]] <= 8'h30 + {4'h0, keyQ};
      end
   end

   // Cells at or beyond count are stale, so count alone decides what is visible.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         charQ <= BLANK;
      end else if ({1'b0, bus.rd_addr} < countQ) begin
         charQ <= cells[bus.rd_addr[AW-1:0]];
      end else begin
         charQ <= BLANK;
      end
   end

   assign bus.char_out       = charQ;
   assign bus.count          = countQ;
   assign bus.full           = (countQ == DEPTH_C);
   assign bus.overrun        = overrunQ;
   assign bus.message_change = pendingQ & bus.lcd_ready;

endmodule
